mem_wb_stage: RTL and testbench

- Memory stage plus MEM/WB pipeline register of the RISC-V pipeline. It produces every signal the writeback result-select logic consumes: MEM_WB_ALU_result, MEM_WB_ReadData, MEM_WB_pcPlus4 and MEM_WB_ResultSrc.
- Issues load/store requests to data memory over a valid/ready request channel and a valid response channel.
- Aligns and sign- or zero-extends load data.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_wb_stage_pkg.sv | 42 ++++
 rtl/mem_wb_stage_load_align.sv | 40 ++++
 rtl/mem_wb_stage.sv | 195 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
// Shared definitions for the memory stage and MEM/WB pipeline register:
//   - funct3 encodings for loads and stores
//   - ResultSrc encodings used by the writeback result mux
//   - memory-access FSM state type
//   - helper that decides whether an access is misaligned or illegal
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_RSP = 1'b1
   } memState_e;

   // Stores share the load encodings for their size bits, so one check covers
   // both directions. The three unused funct3 codes are reported as faults so
   // that they never reach the memory.
   function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_LB, F3_LBU: return 1'b0;
         F3_LH, F3_LHU: return off[0];
         F3_LW:         return (off != 2'b00);
         default:       return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Purely combinational load formatter: picks the addressed byte or halfword
// out of the returned memory word and sign- or zero-extends it.
// Ports:
//   rdata_i  - raw word returned by data memory
//   off_i    - byte offset of the access (address bits [1:0])
//   funct3_i - load size/sign encoding
//   data_o   - aligned, extended value for writeback
// ---------------------------------------------------------------------------
module load_align
   import mem_wb_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      off_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // Lane selection first, then extension according to the load flavour.
   // Halfwords are only ever taken from an even offset, so off_i[1] alone
   // picks the lane.
   always_comb begin
      byteSel = rdata_i[{off_i, 3'b000} +: 8];
      halfSel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_LB:   data_o = {{(XLEN-8){byteSel[7]}}, byteSel};
         F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byteSel};
         F3_LH:   data_o = {{(XLEN-16){halfSel[15]}}, halfSel};
         F3_LHU:  data_o = {{(XLEN-16){1'b0}}, halfSel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory stage plus MEM/WB pipeline register of the RISC-V pipeline.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   EX_MEM_*              - instruction held in the EX/MEM register
//   dmem_req_*/dmem_addr/ - valid/ready request channel to data memory
//   dmem_we/wstrb/wdata     (stores are posted, loads wait for a response)
//   dmem_rsp_*            - load response channel
//   mem_stall             - freezes PC/IF/ID/EX/EX_MEM while memory is busy
//   misaligned_exc        - the instruction now in MEM/WB faulted
//   MEM_WB_*              - registered values consumed by writeback
// ---------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC4 = XLEN'(32'h0000_0004)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            EX_MEM_valid,
   input  logic [XLEN-1:0] EX_MEM_ALU_result,
   input  logic [XLEN-1:0] EX_MEM_WriteData,
   input  logic [XLEN-1:0] EX_MEM_pcPlus4,
   input  logic [4:0]      EX_MEM_rd,
   input  logic            EX_MEM_RegWrite,
   input  logic            EX_MEM_MemRead,
   input  logic            EX_MEM_MemWrite,
   input  logic [2:0]      EX_MEM_funct3,
   input  logic [1:0]      EX_MEM_ResultSrc,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_addr,
   output logic            dmem_we,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_rdata,
   output logic            mem_stall,
   output logic            misaligned_exc,
   output logic            MEM_WB_valid,
   output logic [XLEN-1:0] MEM_WB_ALU_result,
   output logic [XLEN-1:0] MEM_WB_ReadData,
   output logic [XLEN-1:0] MEM_WB_pcPlus4,
   output logic [1:0]      MEM_WB_ResultSrc,
   output logic [4:0]      MEM_WB_rd,
   output logic            MEM_WB_RegWrite
);

   memState_e       state_q, state_d;
   logic [1:0]      off;
   logic            memOp, isLoad, isStore, misaligned, access;
   logic            reqValid, reqWe, stall;
   logic [3:0]      storeStrb;
   logic [XLEN-1:0] storeData;
   logic [XLEN-1:0] alignedData;
   logic [XLEN-1:0] wbReadData;

   logic            valid_q, regWrite_q, misalignedExc_q;
   logic [XLEN-1:0] aluResult_q, readData_q, pcPlus4_q;
   logic [1:0]      resultSrc_q;
   logic [4:0]      rd_q;

   assign off = EX_MEM_ALU_result[1:0];

   // Classify the EX/MEM instruction. A load/store with both flags set is a
   // load, and faulting accesses never touch memory.
   always_comb begin
      memOp      = EX_MEM_valid & (EX_MEM_MemRead | EX_MEM_MemWrite);
      isLoad     = memOp & EX_MEM_MemRead;
      isStore    = memOp & ~EX_MEM_MemRead;
      misaligned = memOp & isMisaligned(EX_MEM_funct3, off);
      access     = memOp & ~misaligned;
   end

   // Byte enables and lane-replicated data so the memory can take the
   // store straight off the bus regardless of the byte offset.
   always_comb begin
      storeStrb = 4'b0000;
      storeData = EX_MEM_WriteData;
      case (EX_MEM_funct3[1:0])
         F3_SB[1:0]: begin
            storeStrb = 4'b0001 << off;
            storeData = {(XLEN/8){EX_MEM_WriteData[7:0]}};
         end
         F3_SH[1:0]: begin
            storeStrb = 4'b0011 << off;
            storeData = {(XLEN/16){EX_MEM_WriteData[15:0]}};
         end
         F3_SW[1:0]: begin
            storeStrb = 4'b1111;
            storeData = EX_MEM_WriteData;
         end
         default: begin
            storeStrb = 4'b0000;
            storeData = EX_MEM_WriteData;
         end
      endcase
   end

   // Request/stall control. In IDLE the request is raised combinationally so
   // a ready memory completes a store in the same cycle. Loads always stall
   // in IDLE because the data cannot come back before the next cycle. In
   // WAIT_RSP the stall drops in the cycle the response shows up so that the
   // load retires into MEM/WB on that edge.
   always_comb begin
      state_d  = state_q;
      reqValid = 1'b0;
      reqWe    = 1'b0;
      stall    = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               reqValid = 1'b1;
               reqWe    = isStore;
               if (isLoad) begin
                  stall = 1'b1;
                  if (dmem_req_ready) state_d = WAIT_RSP;
               end else begin
                  stall = ~dmem_req_ready;
               end
            end
         end
         WAIT_RSP: begin
            stall = ~dmem_rsp_valid;
            if (dmem_rsp_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   load_align #(.XLEN(XLEN)) u_load_align (
      .rdata_i  (dmem_rsp_rdata),
      .off_i    (off),
      .funct3_i (EX_MEM_funct3),
      .data_o   (alignedData)
   );

   // Only a load retiring out of WAIT_RSP carries memory data; everything
   // else writes zero so stale load data never lingers in MEM/WB.
   assign wbReadData = (state_q == WAIT_RSP) ? alignedData : '0;

   // Memory-side outputs are zeroed whenever no request is being presented.
   assign dmem_req_valid = reqValid;
   assign dmem_we        = reqWe;
   assign dmem_addr      = reqValid ? {EX_MEM_ALU_result[XLEN-1:2], 2'b00} : '0;
   assign dmem_wstrb     = (reqValid & reqWe) ? storeStrb : 4'b0000;
   assign dmem_wdata     = (reqValid & reqWe) ? storeData : '0;
   assign mem_stall      = stall;

   // FSM state plus the MEM/WB register. A stalled cycle writes a bubble
   // (valid and write enable cleared) so a held instruction cannot be written
   // back twice. The write enable is also masked for non-instructions and
   // faulting accesses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         valid_q         <= 1'b0;
         regWrite_q      <= 1'b0;
         misalignedExc_q <= 1'b0;
         aluResult_q     <= '0;
         readData_q      <= '0;
         pcPlus4_q       <= RESET_PC4;
         resultSrc_q     <= 2'b00;
         rd_q            <= 5'd0;
      end else begin
         state_q <= state_d;
         if (stall) begin
            valid_q         <= 1'b0;
            regWrite_q      <= 1'b0;
            misalignedExc_q <= 1'b0;
         end else begin
            valid_q         <= EX_MEM_valid;
            regWrite_q      <= EX_MEM_valid & EX_MEM_RegWrite & ~misaligned;
            misalignedExc_q <= misaligned;
            aluResult_q     <= EX_MEM_ALU_result;
            readData_q      <= wbReadData;
            pcPlus4_q       <= EX_MEM_pcPlus4;
            resultSrc_q     <= EX_MEM_ResultSrc;
            rd_q            <= EX_MEM_rd;
         end
      end
   end

   assign misaligned_exc    = misalignedExc_q;
   assign MEM_WB_valid      = valid_q;
   assign MEM_WB_RegWrite   = regWrite_q;
   assign MEM_WB_ALU_result = aluResult_q;
   assign MEM_WB_ReadData   = readData_q;
   assign MEM_WB_pcPlus4    = pcPlus4_q;
   assign MEM_WB_ResultSrc  = resultSrc_q;
   assign MEM_WB_rd         = rd_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
// Drives the memory stage as both the EX/MEM register and the data memory,
// and compares every cycle against a transaction-level model of the stage.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

   logic        clock = 1'b0;
   logic        resetN;
   logic        exValid, exRegWrite, exMemRead, exMemWrite;
   logic [31:0] exAlu, exWdata, exPc4;
   logic [4:0]  exRd;
   logic [2:0]  exFunct3;
   logic [1:0]  exResSrc;
   logic        reqReady, rspValid;
   logic [31:0] rspRdata;

   logic        reqValid, reqWe, memStall, misExc;
   logic [31:0] reqAddr, reqWdata;
   logic [3:0]  reqWstrb;
   logic        wbValid, wbRegWrite;
   logic [31:0] wbAlu, wbReadData, wbPc4;
   logic [1:0]  wbResSrc;
   logic [4:0]  wbRd;

   int totalChecks = 0;
   int badChecks   = 0;
   int stallSeen;

   mem_wb_stage dut (
      .clk               (clock),
      .rst_n             (resetN),
      .EX_MEM_valid      (exValid),
      .EX_MEM_ALU_result (exAlu),
      .EX_MEM_WriteData  (exWdata),
      .EX_MEM_pcPlus4    (exPc4),
      .EX_MEM_rd         (exRd),
      .EX_MEM_RegWrite   (exRegWrite),
      .EX_MEM_MemRead    (exMemRead),
      .EX_MEM_MemWrite   (exMemWrite),
      .EX_MEM_funct3     (exFunct3),
      .EX_MEM_ResultSrc  (exResSrc),
      .dmem_req_valid    (reqValid),
      .dmem_req_ready    (reqReady),
      .dmem_addr         (reqAddr),
      .dmem_we           (reqWe),
      .dmem_wstrb        (reqWstrb),
      .dmem_wdata        (reqWdata),
      .dmem_rsp_valid    (rspValid),
      .dmem_rsp_rdata    (rspRdata),
      .mem_stall         (memStall),
      .misaligned_exc    (misExc),
      .MEM_WB_valid      (wbValid),
      .MEM_WB_ALU_result (wbAlu),
      .MEM_WB_ReadData   (wbReadData),
      .MEM_WB_pcPlus4    (wbPc4),
      .MEM_WB_ResultSrc  (wbResSrc),
      .MEM_WB_rd         (wbRd),
      .MEM_WB_RegWrite   (wbRegWrite)
   );

   // Free-running pipeline clock.
   always #5 clock = ~clock;

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Reference load formatter written with shifts and masks on integers.
   function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
      int unsigned offInt;
      int unsigned v;
      offInt = off;
      case (f3)
         3'd0: begin
            v = (word >> (8 * offInt)) & 32'hFF;
            if (v >= 128) v = v + 32'hFFFF_FF00;
         end
         3'd4: v = (word >> (8 * offInt)) & 32'hFF;
         3'd1: begin
            v = (word >> (16 * (offInt / 2))) & 32'hFFFF;
            if (v >= 32768) v = v + 32'hFFFF_0000;
         end
         3'd5: v = (word >> (16 * (offInt / 2))) & 32'hFFFF;
         default: v = word;
      endcase
      return v;
   endfunction

   // Presents one instruction and plays the memory with the given ready and
   // response delays (response rspDelay cycles after the handshake). Every
   // cycle the combinational outputs and the MEM/WB register are compared
   // with what the transaction model predicts.
   task automatic applyStimulus(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] pc4, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [1:0] rs, input int readyDelay, input int rspDelay,
                                input logic [31:0] rdata);
      logic        isMemOp, isLoad, isStore, mis, access, inReq, expStall;
      int unsigned size, lastCycle, hsCycle, rspCycle;
      logic [3:0]  expStrb;
      logic [31:0] expWdata, expRead;
      isMemOp  = v && (mr || mw);
      isLoad   = isMemOp && mr;
      isStore  = isMemOp && !mr;
      size     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      mis      = isMemOp && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((alu % size) != 0));
      access   = isMemOp && !mis;
      hsCycle  = readyDelay;
      rspCycle = readyDelay + rspDelay;
      lastCycle = !access ? 0 : (isLoad ? rspCycle : hsCycle);
      expStrb  = 4'(((1 << size) - 1) << (alu % 4));
      expWdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      expRead  = (isLoad && !mis) ? modelLoad(rdata, alu[1:0], f3) : 32'h0;
      stallSeen = 0;
      for (int c = 0; c <= int'(lastCycle); c++) begin
         @(negedge clock);
         if (c == 0) begin
            exValid = v; exAlu = alu; exWdata = wd; exPc4 = pc4; exRd = rd;
            exRegWrite = rw; exMemRead = mr; exMemWrite = mw; exFunct3 = f3; exResSrc = rs;
         end
         inReq = access && (c <= int'(hsCycle));
         if (access && isLoad) begin
            reqReady = inReq ? (c == int'(hsCycle)) : 1'($urandom_range(0, 1));
            rspValid = (c < int'(hsCycle)) ? 1'($urandom_range(0, 1)) : (c == int'(rspCycle));
            rspRdata = (c == int'(rspCycle)) ? rdata : $urandom;
         end else begin
            reqReady = access ? (c == int'(hsCycle)) : 1'($urandom_range(0, 1));
            rspValid = 1'($urandom_range(0, 1));
            rspRdata = $urandom;
         end
         #1;
         expStall = inReq ? (isLoad || (c < int'(hsCycle))) : (access && isLoad && (c < int'(rspCycle)));
         if (memStall === 1'b1) stallSeen++;
         checkOutput("reqValid", 32'(reqValid), 32'(inReq));
         checkOutput("memStall", 32'(memStall), 32'(expStall));
         if (inReq) begin
            checkOutput("reqAddr", reqAddr, alu & 32'hFFFF_FFFC);
            checkOutput("reqWe", 32'(reqWe), 32'(isStore));
            checkOutput("reqWstrb", 32'(reqWstrb), isStore ? 32'(expStrb) : 32'h0);
            if (isStore) checkOutput("reqWdata", reqWdata, expWdata);
         end
         @(posedge clock);
         #1;
         if (expStall) begin
            checkOutput("bubbleValid", 32'(wbValid), 32'h0);
            checkOutput("bubbleRegWrite", 32'(wbRegWrite), 32'h0);
         end else begin
            checkOutput("wbValid", 32'(wbValid), 32'(v));
            checkOutput("wbRegWrite", 32'(wbRegWrite), 32'(v && rw && !mis));
            checkOutput("misExc", 32'(misExc), 32'(mis));
            checkOutput("wbAlu", wbAlu, alu);
            checkOutput("wbPc4", wbPc4, pc4);
            checkOutput("wbRd", 32'(wbRd), 32'(rd));
            checkOutput("wbResSrc", 32'(wbResSrc), 32'(rs));
            checkOutput("wbReadData", wbReadData, expRead);
         end
      end
   endtask

   initial begin
      logic [2:0] legalF3 [5];
      logic       v, mr, mw;
      int         kind;
      logic [2:0] f3;
      legalF3[0] = 3'd0; legalF3[1] = 3'd1; legalF3[2] = 3'd2; legalF3[3] = 3'd4; legalF3[4] = 3'd5;

      resetN = 1'b1;
      exValid = 0; exAlu = 0; exWdata = 0; exPc4 = 0; exRd = 0; exRegWrite = 0;
      exMemRead = 0; exMemWrite = 0; exFunct3 = 0; exResSrc = 0;
      reqReady = 0; rspValid = 0; rspRdata = 0;
      #2 resetN = 1'b0;
      #1;
      checkOutput("rstPc4", wbPc4, 32'h4);
      checkOutput("rstValid", 32'(wbValid), 32'h0);
      checkOutput("rstRegWrite", 32'(wbRegWrite), 32'h0);
      checkOutput("rstMisExc", 32'(misExc), 32'h0);
      checkOutput("rstAlu", wbAlu, 32'h0);
      checkOutput("rstReadData", wbReadData, 32'h0);
      checkOutput("rstReqValid", 32'(reqValid), 32'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetN = 1'b1;

      // Directed cases: ALU op, sign-extended byte load, zero-extended
      // halfword load, stalled byte store, misaligned word load.
      applyStimulus(1, 32'h1234, 0, 32'h10, 5'd5, 1, 0, 0, 3'd0, 2'b00, 0, 1, 0);
      checkOutput("aluNoStall", 32'(stallSeen), 32'h0);
      applyStimulus(1, 32'h103, 0, 32'h14, 5'd6, 1, 1, 0, 3'd0, 2'b01, 0, 3, 32'h80FF_0000);
      checkOutput("lbData", wbReadData, 32'hFFFF_FF80);
      checkOutput("lbStallCycles", 32'(stallSeen), 32'h3);
      applyStimulus(1, 32'h102, 0, 32'h18, 5'd7, 1, 1, 0, 3'd5, 2'b01, 1, 1, 32'hBEEF_0000);
      checkOutput("lhuData", wbReadData, 32'h0000_BEEF);
      applyStimulus(1, 32'h201, 32'h0000_00AB, 32'h1C, 5'd0, 0, 0, 1, 3'd0, 2'b00, 2, 1, 0);
      checkOutput("sbStallCycles", 32'(stallSeen), 32'h2);
      applyStimulus(1, 32'h102, 0, 32'h20, 5'd8, 1, 1, 0, 3'd2, 2'b01, 0, 1, 32'h1111_2222);
      checkOutput("lwMisExc", 32'(misExc), 32'h1);
      checkOutput("lwMisRegWrite", 32'(wbRegWrite), 32'h0);

      // Reset while a load is outstanding, then a late response.
      @(negedge clock);
      exValid = 1; exMemRead = 1; exMemWrite = 0; exFunct3 = 3'd2; exAlu = 32'h300;
      exRegWrite = 1; reqReady = 1; rspValid = 0;
      @(posedge clock);
      #1;
      checkOutput("preRstStall", 32'(memStall), 32'h1);
      @(negedge clock);
      resetN = 1'b0;
      exValid = 0; exMemRead = 0; exRegWrite = 0; exAlu = 0; exPc4 = 32'h4;
      exRd = 0; exResSrc = 0; exFunct3 = 0; reqReady = 0;
      #1;
      checkOutput("midRstPc4", wbPc4, 32'h4);
      checkOutput("midRstValid", 32'(wbValid), 32'h0);
      checkOutput("midRstStall", 32'(memStall), 32'h0);
      @(negedge clock);
      resetN = 1'b1;
      rspValid = 1; rspRdata = 32'hDEAD_BEEF;
      #1;
      checkOutput("lateRspStall", 32'(memStall), 32'h0);
      checkOutput("lateRspReq", 32'(reqValid), 32'h0);
      @(posedge clock);
      #1;
      checkOutput("lateRspReadData", wbReadData, 32'h0);
      checkOutput("lateRspValid", 32'(wbValid), 32'h0);
      checkOutput("lateRspRegWrite", 32'(wbRegWrite), 32'h0);
      checkOutput("lateRspPc4", wbPc4, 32'h4);

      // Randomized instruction stream with random memory timing.
      for (int i = 0; i < 200; i++) begin
         kind = $urandom_range(0, 3);
         v    = ($urandom_range(0, 9) != 0);
         mr   = (kind == 1) || (kind == 3);
         mw   = (kind == 2) || (kind == 3);
         f3   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legalF3[$urandom_range(0, 4)];
         applyStimulus(v, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)), mr, mw, f3, 2'($urandom_range(0, 2)),
                       $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
